// File: rtl/lbp_scan_ctrl_if.sv
// Handshake bundle between the LBP scan sequencer, the gray/result
// memories and the LBP window datapath.
interface lbp_scan_ctrl_if #(
    parameter int AW = 14
);
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic          win_ld;
    logic [1:0]    win_row;
    logic [1:0]    win_col;
    logic          win_shift;
    logic [7:0]    lbp_code;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;

    modport master (
        input  gray_ready, lbp_code,
        output gray_req, gray_addr, win_ld, win_row, win_col, win_shift,
               lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, lbp_code,
        input  gray_req, gray_addr, win_ld, win_row, win_col, win_shift,
               lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface

// File: rtl/lbp_scan_ctrl.sv
// LBP frame sequencer: schedules gray-memory reads into the 3x3 window,
// captures the LBP code and writes it for every interior pixel.
//
// Every output is a flop. The FSM state seen at a clock edge decides what
// the following cycle presents on the bus:
//
//   state | meaning
//   IDLE  | waiting for gray_ready before starting the frame
//   FILL  | issue the next of 9 column-major reads for a fresh window
//   SLIDE | issue the next of 3 reads for the new right-hand column
//   CALC  | no bus activity; datapath settles lbp_code on the full window
//   WRITE | capture lbp_code, present the result write, pick next pixel
//   DONE  | frame complete, finish held until reset
module lbp_scan_ctrl #(
    parameter int LOG_W = 7,
    parameter int LOG_H = 7
) (
    input  logic            clk,
    input  logic            reset,
    lbp_scan_ctrl_if.master bus
);
    localparam int AW = LOG_W + LOG_H;
    localparam logic [LOG_W-1:0] C_LAST = LOG_W'((1 << LOG_W) - 2);
    localparam logic [LOG_H-1:0] R_LAST = LOG_H'((1 << LOG_H) - 2);

    typedef enum logic [2:0] {IDLE, FILL, SLIDE, CALC, WRITE, DONE} state_t;

    state_t           state_q, state_d;
    logic [LOG_H-1:0] r_q, r_d;
    logic [LOG_W-1:0] c_q, c_d;
    logic [1:0]       ld_row_q, ld_row_d;
    logic [1:0]       ld_col_q, ld_col_d;

    logic             gray_req_q, gray_req_d;
    logic [AW-1:0]    gray_addr_q, gray_addr_d;
    logic             win_ld_q, win_ld_d;
    logic [1:0]       win_row_q, win_row_d;
    logic [1:0]       win_col_q, win_col_d;
    logic             win_shift_q, win_shift_d;
    logic             lbp_valid_q, lbp_valid_d;
    logic [AW-1:0]    lbp_addr_q, lbp_addr_d;
    logic [7:0]       lbp_data_q, lbp_data_d;
    logic             finish_q, finish_d;

    logic [1:0]       src_col;
    logic [LOG_H-1:0] rd_row;
    logic [LOG_W-1:0] rd_col;

    // Address of the pending read; a slide always targets window column 2.
    always_comb begin
        src_col = (state_q == SLIDE) ? 2'd2 : ld_col_q;
        rd_row  = r_q + LOG_H'(ld_row_q) - LOG_H'(1);
        rd_col  = c_q + LOG_W'(src_col) - LOG_W'(1);
    end

    // Next-state, counter and next-output logic.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        ld_row_d    = ld_row_q;
        ld_col_d    = ld_col_q;
        gray_req_d  = 1'b0;
        gray_addr_d = gray_addr_q;
        win_ld_d    = 1'b0;
        win_row_d   = 2'd0;
        win_col_d   = 2'd0;
        win_shift_d = 1'b0;
        lbp_valid_d = 1'b0;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;
        finish_d    = finish_q;

        case (state_q)
            IDLE: begin
                if (bus.gray_ready) begin
                    state_d = FILL;
                end
            end
            FILL, SLIDE: begin
                // A low gray_ready freezes everything; the same read is retried.
                if (bus.gray_ready) begin
                    gray_req_d  = 1'b1;
                    gray_addr_d = {rd_row, rd_col};
                    win_ld_d    = 1'b1;
                    win_row_d   = ld_row_q;
                    win_col_d   = src_col;
                    if (ld_row_q == 2'd2) begin
                        ld_row_d = 2'd0;
                        if (state_q == SLIDE || ld_col_q == 2'd2) begin
                            ld_col_d = 2'd0;
                            state_d  = CALC;
                        end else begin
                            ld_col_d = ld_col_q + 2'd1;
                        end
                    end else begin
                        ld_row_d = ld_row_q + 2'd1;
                    end
                end
            end
            CALC: begin
                state_d = WRITE;
            end
            WRITE: begin
                lbp_valid_d = 1'b1;
                lbp_addr_d  = {r_q, c_q};
                lbp_data_d  = bus.lbp_code;
                if (c_q < C_LAST) begin
                    c_d         = c_q + LOG_W'(1);
                    win_shift_d = 1'b1;
                    state_d     = SLIDE;
                end else if (r_q < R_LAST) begin
                    r_d     = r_q + LOG_H'(1);
                    c_d     = LOG_W'(1);
                    state_d = FILL;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                finish_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            r_q         <= LOG_H'(1);
            c_q         <= LOG_W'(1);
            ld_row_q    <= 2'd0;
            ld_col_q    <= 2'd0;
            gray_req_q  <= 1'b0;
            gray_addr_q <= '0;
            win_ld_q    <= 1'b0;
            win_row_q   <= 2'd0;
            win_col_q   <= 2'd0;
            win_shift_q <= 1'b0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= 8'd0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            ld_row_q    <= ld_row_d;
            ld_col_q    <= ld_col_d;
            gray_req_q  <= gray_req_d;
            gray_addr_q <= gray_addr_d;
            win_ld_q    <= win_ld_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_shift_q <= win_shift_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
            finish_q    <= finish_d;
        end
    end

    assign bus.gray_req  = gray_req_q;
    assign bus.gray_addr = gray_addr_q;
    assign bus.win_ld    = win_ld_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.win_shift = win_shift_q;
    assign bus.lbp_valid = lbp_valid_q;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_data  = lbp_data_q;
    assign bus.finish    = finish_q;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench for lbp_scan_ctrl on a 128x64 frame with a behavioural window
// datapath, gray memory and result memory.
module tb_lbp_scan_ctrl;
    localparam int LOG_W      = 7;
    localparam int LOG_H      = 6;
    localparam int W          = 1 << LOG_W;
    localparam int H          = 1 << LOG_H;
    localparam int AW         = LOG_W + LOG_H;
    localparam int N_PIX      = W * H;
    localparam int EXP_WRITES = (H - 2) * (W - 2);
    localparam int EXP_LAST   = (H - 2) * W + (W - 2);
    localparam int EXP_CYC    = (H - 2) * (11 + (W - 3) * 5);
    localparam int STALL      = 4;

    logic clk = 1'b0;
    logic reset;
    logic rmem_clr;

    lbp_scan_ctrl_if #(.AW(AW)) bus ();

    lbp_scan_ctrl #(.LOG_W(LOG_W), .LOG_H(LOG_H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] gmem [N_PIX];
    logic [7:0] rmem [N_PIX];
    logic [7:0] win  [3][3];

    function automatic logic [7:0] lbp_fn(input logic [7:0] tl, tc, tr, rr, br, bc, bl, ll, ctr);
        return {ll >= ctr, bl >= ctr, bc >= ctr, br >= ctr, rr >= ctr, tr >= ctr, tc >= ctr, tl >= ctr};
    endfunction

    function automatic logic [7:0] gpx(input int r, input int c);
        return gmem[r * W + c];
    endfunction

    function automatic logic [7:0] golden(input int r, input int c);
        if (r == 0 || c == 0 || r == H - 1 || c == W - 1) return 8'd0;
        return lbp_fn(gpx(r-1, c-1), gpx(r-1, c), gpx(r-1, c+1), gpx(r, c+1),
                      gpx(r+1, c+1), gpx(r+1, c), gpx(r+1, c-1), gpx(r, c-1), gpx(r, c));
    endfunction

    // Window datapath model
    always @(posedge clk) begin
        if (bus.win_shift) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
        end
        if (bus.win_ld) win[bus.win_row][bus.win_col] <= gmem[bus.gray_addr];
    end

    always_comb bus.lbp_code = lbp_fn(win[0][0], win[0][1], win[0][2], win[1][2],
                                      win[2][2], win[2][1], win[2][0], win[1][0], win[1][1]);

    // Result memory model
    always @(posedge clk) begin
        if (rmem_clr) begin
            for (int i = 0; i < N_PIX; i++) rmem[i] <= 8'd0;
        end else if (bus.lbp_valid) begin
            rmem[bus.lbp_addr] <= bus.lbp_data;
        end
    end

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic gr;
        logic req;
        int   addr;
        int   row;
        int   col;
        logic shift;
        logic valid;
        int   laddr;
        logic calc;
    } vec_t;
    vec_t tv[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_wr, last_addr, t_first, t_fin, t_last_wr;
    bit req_seen, fin_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame();
        sb.delete();
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                sb.push_back('{r * W + c, golden(r, c)});
    endtask

    // One cycle: step to the falling edge, then run the per-cycle monitors.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (bus.win_ld || bus.win_shift)
            chk("ld_shift_exclusive", int'(bus.win_ld & bus.win_shift), 0);
        if (bus.gray_req && !req_seen) begin
            req_seen = 1'b1;
            t_first  = cyc;
        end
        if (bus.lbp_valid) begin
            n_wr++;
            last_addr = int'(bus.lbp_addr);
            t_last_wr = cyc;
            if (sb.size() == 0) begin
                chk("sb_unexpected_write_addr", int'(bus.lbp_addr), -1);
            end else begin
                e = sb.pop_front();
                chk("sb_write_addr*256+data", int'(bus.lbp_addr) * 256 + int'(bus.lbp_data),
                    e.addr * 256 + int'(e.data));
            end
        end
        if (bus.finish && !fin_seen) begin
            fin_seen = 1'b1;
            t_fin    = cyc;
            chk("writes_before_finish", n_wr, EXP_WRITES);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gray_req"},  int'(bus.gray_req), 0);
        chk({tag, "_gray_addr"}, int'(bus.gray_addr), 0);
        chk({tag, "_win_ld"},    int'(bus.win_ld), 0);
        chk({tag, "_win_rc"},    int'({bus.win_row, bus.win_col}), 0);
        chk({tag, "_win_shift"}, int'(bus.win_shift), 0);
        chk({tag, "_lbp_valid"}, int'(bus.lbp_valid), 0);
        chk({tag, "_lbp_addr"},  int'(bus.lbp_addr), 0);
        chk({tag, "_lbp_data"},  int'(bus.lbp_data), 0);
        chk({tag, "_finish"},    int'(bus.finish), 0);
    endtask

    function automatic vec_t v_idle(input logic gr);
        return '{gr, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0};
    endfunction
    function automatic vec_t v_rd(input int a, input int r, input int c);
        return '{1'b1, 1'b1, a, r, c, 1'b0, 1'b0, 0, 1'b0};
    endfunction
    function automatic vec_t v_calc();
        return '{1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1};
    endfunction
    function automatic vec_t v_wr(input int la, input logic sh);
        return '{1'b1, 1'b0, 0, 0, 0, sh, 1'b1, la, 1'b0};
    endfunction

    initial begin
        bit   found;
        int   got [3];
        int   n;
        logic [7:0] code_calc;

        code_calc = 8'd0;
        // Table: start idle, first FILL with a 4-cycle stall after the 5th read,
        // then the first slide.
        tv.push_back(v_idle(1'b0));
        tv.push_back(v_idle(1'b0));
        tv.push_back(v_idle(1'b1));
        tv.push_back(v_rd(0, 0, 0));
        tv.push_back(v_rd(128, 1, 0));
        tv.push_back(v_rd(256, 2, 0));
        tv.push_back(v_rd(1, 0, 1));
        tv.push_back(v_rd(129, 1, 1));
        for (int i = 0; i < STALL; i++) tv.push_back(v_idle(1'b0));
        tv.push_back(v_rd(257, 2, 1));
        tv.push_back(v_rd(2, 0, 2));
        tv.push_back(v_rd(130, 1, 2));
        tv.push_back(v_rd(258, 2, 2));
        tv.push_back(v_calc());
        tv.push_back(v_wr(129, 1'b1));
        tv.push_back(v_rd(3, 0, 2));
        tv.push_back(v_rd(131, 1, 2));
        tv.push_back(v_rd(259, 2, 2));
        tv.push_back(v_calc());
        tv.push_back(v_wr(130, 1'b1));
        tv.push_back(v_rd(4, 0, 2));

        for (int i = 0; i < N_PIX; i++) gmem[i] = 8'($urandom_range(0, 7));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) win[r][c] = 8'd0;

        reset          = 1'b0;
        rmem_clr       = 1'b1;
        bus.gray_ready = 1'b0;
        n_wr = 0; last_addr = -1; t_first = 0; t_fin = 0; t_last_wr = 0;
        req_seen = 1'b0; fin_seen = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");

        // Frame aborted by reset at the write to 5000.
        reset          = 1'b1;
        rmem_clr       = 1'b0;
        bus.gray_ready = 1'b1;
        push_frame();
        found = 1'b0;
        for (int i = 0; i < 30000 && !found; i++) begin
            tick();
            if (bus.lbp_valid && int'(bus.lbp_addr) == 5000) found = 1'b1;
        end
        chk("reached_write_5000", int'(found), 1);
        #2 reset = 1'b0;
        #1 chk_all_zero("async_reset");
        sb.delete();
        bus.gray_ready = 1'b0;
        rmem_clr       = 1'b1;
        repeat (3) tick();
        rmem_clr = 1'b0;
        n_wr = 0; last_addr = -1; req_seen = 1'b0; fin_seen = 1'b0;
        push_frame();
        reset = 1'b1;

        // Cycle-accurate table for the start of the restarted frame.
        for (int i = 0; i < tv.size(); i++) begin
            bus.gray_ready = tv[i].gr;
            tick();
            chk($sformatf("v%0d_gray_req", i),  int'(bus.gray_req),  int'(tv[i].req));
            chk($sformatf("v%0d_win_ld", i),    int'(bus.win_ld),    int'(tv[i].req));
            chk($sformatf("v%0d_win_shift", i), int'(bus.win_shift), int'(tv[i].shift));
            chk($sformatf("v%0d_lbp_valid", i), int'(bus.lbp_valid), int'(tv[i].valid));
            chk($sformatf("v%0d_finish", i),    int'(bus.finish),    0);
            if (tv[i].req) begin
                chk($sformatf("v%0d_gray_addr", i), int'(bus.gray_addr), tv[i].addr);
                chk($sformatf("v%0d_win_row", i),   int'(bus.win_row),   tv[i].row);
                chk($sformatf("v%0d_win_col", i),   int'(bus.win_col),   tv[i].col);
            end
            if (tv[i].calc) code_calc = bus.lbp_code;
            if (tv[i].valid) begin
                chk($sformatf("v%0d_lbp_addr", i), int'(bus.lbp_addr), tv[i].laddr);
                chk($sformatf("v%0d_lbp_data_vs_calc_code", i), int'(bus.lbp_data), int'(code_calc));
            end
        end

        // End of the first row: no shift, then a fresh FILL one row down.
        bus.gray_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (bus.lbp_valid && int'(bus.lbp_addr) == 2 * W - 2) found = 1'b1;
        end
        chk("reached_row_end_write", int'(found), 1);
        chk("row_end_no_shift", int'(bus.win_shift), 0);
        got = '{-1, -1, -1};
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            tick();
            if (bus.gray_req) begin
                got[n] = int'(bus.gray_addr);
                n++;
            end
        end
        for (int k = 0; k < 3; k++) chk($sformatf("row2_fill_addr%0d", k), got[k], (k + 1) * W);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.lbp_valid) begin
                found = 1'b1;
                chk("row2_first_write_addr", int'(bus.lbp_addr), 2 * W + 1);
            end
        end
        chk("row2_write_seen", int'(found), 1);

        // Run out the frame.
        for (int i = 0; i < 60000 && !fin_seen; i++) tick();
        chk("finish_seen", int'(fin_seen), 1);
        chk("write_count", n_wr, EXP_WRITES);
        chk("last_lbp_addr", last_addr, EXP_LAST);
        chk("frame_cycles", t_fin - t_first, EXP_CYC + STALL);
        chk("finish_after_last_write", t_fin - t_last_wr, 1);
        chk("scoreboard_drained", sb.size(), 0);
        repeat (5) tick();
        chk("finish_sticky", int'(bus.finish), 1);
        chk("done_no_req", int'(bus.gray_req), 0);
        chk("done_no_valid", int'(bus.lbp_valid), 0);

        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                n_cmp++;
                if (rmem[r * W + c] !== golden(r, c)) begin
                    n_err++;
                    $display("FAIL rmem[%0d,%0d]: got %0d expected %0d", r, c,
                             rmem[r * W + c], golden(r, c));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
